// File: rtl/perf_counter_unit_pkg.sv
// Shared register offsets and control-field layout for the performance counter unit.
package perf_counter_unit_pkg;

  // Per-counter word offsets within a 4-word counter block.
  localparam int unsigned PCU_EVSEL    = 0;
  localparam int unsigned PCU_CTRL     = 1;
  localparam int unsigned PCU_COUNT_LO = 2;
  localparam int unsigned PCU_COUNT_HI = 3;

  // Global word offsets, placed after the last counter block.
  localparam int unsigned PCU_OVF   = 0;
  localparam int unsigned PCU_GCTRL = 1;

  typedef struct packed {
    logic irq_en;
    logic enable;
  } pcu_ctrl_t;

endpackage

// File: rtl/perf_counter_unit_if.sv
// 32-bit control-register port of the performance counter unit.
interface perf_counter_unit_if #(
  parameter int unsigned AddrWidth = 8
) ();
  logic                 write_en;
  logic                 read_en;
  logic [AddrWidth-1:0] address;
  logic [31:0]          write_data;
  logic [31:0]          read_data;

  modport master (output write_en, read_en, address, write_data, input read_data);
  modport slave  (input write_en, read_en, address, write_data, output read_data);
endinterface

// File: rtl/perf_counter_unit_slice.sv
// One programmable counter: event select, control, count with wrap, and the hi-half read shadow.
module perf_counter_unit_slice
  import perf_counter_unit_pkg::*;
#(
  parameter int unsigned NumEvents    = 35,
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned EvselWidth   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumEvents-1:0]  evt_i,
  input  logic                  freeze_i,
  input  logic                  clear_i,
  input  logic                  wr_evsel_i,
  input  logic                  wr_ctrl_i,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic [31:0]           wdata_i,
  input  logic                  rd_lo_i,
  output logic [EvselWidth-1:0] evsel_o,
  output pcu_ctrl_t             ctrl_o,
  output logic [31:0]           count_lo_o,
  output logic [31:0]           shadow_o,
  output logic                  ovf_set_o
);

  localparam int unsigned HiWidth  = CounterWidth - 32;
  localparam int unsigned EvPadLen = 2 ** EvselWidth;

  logic [EvselWidth-1:0]   evsel_q, evsel_d;
  pcu_ctrl_t               ctrl_q, ctrl_d;
  logic [CounterWidth-1:0] count_q, count_d;
  logic [31:0]             shadow_q, shadow_d;
  logic [EvPadLen-1:0]     evt_pad;
  logic                    inc;

  // Padding with zeros makes out-of-range selects read as "no event".
  assign evt_pad = EvPadLen'(evt_i);
  assign inc     = ctrl_q.enable & ~freeze_i & evt_pad[evsel_q];

  always_comb begin
    evsel_d   = wr_evsel_i ? wdata_i[EvselWidth-1:0] : evsel_q;
    ctrl_d    = wr_ctrl_i ? pcu_ctrl_t'(wdata_i[1:0]) : ctrl_q;
    shadow_d  = rd_lo_i ? 32'(count_q[CounterWidth-1:32]) : shadow_q;
    count_d   = count_q;
    ovf_set_o = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (wr_lo_i) begin
      count_d = CounterWidth'(wdata_i);
    end else if (wr_hi_i) begin
      count_d = {wdata_i[HiWidth-1:0], count_q[31:0]};
    end else if (inc) begin
      count_d   = count_q + 1'b1;
      ovf_set_o = &count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evsel_q  <= '0;
      ctrl_q   <= '0;
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      evsel_q  <= evsel_d;
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  assign evsel_o    = evsel_q;
  assign ctrl_o     = ctrl_q;
  assign count_lo_o = count_q[31:0];
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Programmable performance counters: address decode, read mux, overflow status, global control, irq.
module perf_counter_unit
  import perf_counter_unit_pkg::*;
#(
  parameter int unsigned NumEvents    = 35,
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned CrAddrWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumEvents-1:0] perf_event_i,
  perf_counter_unit_if.slave   cr,
  output logic                 overflow_irq_o
);

  localparam int unsigned EvselWidth = (NumEvents > 1) ? $clog2(NumEvents) : 1;
  localparam int unsigned GlobalBase = 4 * NumCounters;

  logic [NumEvents-1:0]   evt_q;
  logic                   freeze_q, freeze_d;
  logic [NumCounters-1:0] ovf_q, ovf_d, ovf_set, irq_en_vec;
  logic                   irq_q, irq_d;
  logic [31:0]            rdata_q, rdata_d, rd_word;

  logic [CrAddrWidth-1:0] addr;
  int unsigned            addr_int, slot;
  logic [1:0]             offset;
  logic                   wr_ovf, wr_gctrl, clear_all;

  logic [EvselWidth-1:0]  evsel    [NumCounters];
  pcu_ctrl_t              ctrl     [NumCounters];
  logic [31:0]            count_lo [NumCounters];
  logic [31:0]            shadow   [NumCounters];

  assign addr      = cr.address;
  assign addr_int  = 32'(addr);
  assign slot      = addr_int >> 2;
  assign offset    = addr[1:0];
  assign wr_ovf    = cr.write_en && (addr_int == GlobalBase + PCU_OVF);
  assign wr_gctrl  = cr.write_en && (addr_int == GlobalBase + PCU_GCTRL);
  assign clear_all = wr_gctrl && cr.write_data[1];

  for (genvar i = 0; i < NumCounters; i++) begin : g_slice
    logic sel;
    assign sel = (slot == i);

    perf_counter_unit_slice #(
      .NumEvents   (NumEvents),
      .CounterWidth(CounterWidth),
      .EvselWidth  (EvselWidth)
    ) u_slice (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .evt_i     (evt_q),
      .freeze_i  (freeze_q),
      .clear_i   (clear_all),
      .wr_evsel_i(cr.write_en && sel && (offset == 2'(PCU_EVSEL))),
      .wr_ctrl_i (cr.write_en && sel && (offset == 2'(PCU_CTRL))),
      .wr_lo_i   (cr.write_en && sel && (offset == 2'(PCU_COUNT_LO))),
      .wr_hi_i   (cr.write_en && sel && (offset == 2'(PCU_COUNT_HI))),
      .wdata_i   (cr.write_data),
      .rd_lo_i   (cr.read_en && sel && (offset == 2'(PCU_COUNT_LO))),
      .evsel_o   (evsel[i]),
      .ctrl_o    (ctrl[i]),
      .count_lo_o(count_lo[i]),
      .shadow_o  (shadow[i]),
      .ovf_set_o (ovf_set[i])
    );

    assign irq_en_vec[i] = ctrl[i].irq_en;
  end

  always_comb begin
    rd_word = '0;
    if (slot < NumCounters) begin
      for (int i = 0; i < NumCounters; i++) begin
        if (slot == 32'(i)) begin
          case (offset)
            2'(PCU_EVSEL):    rd_word = 32'(evsel[i]);
            2'(PCU_CTRL):     rd_word = 32'(ctrl[i]);
            2'(PCU_COUNT_LO): rd_word = count_lo[i];
            2'(PCU_COUNT_HI): rd_word = shadow[i];
            default:          rd_word = '0;
          endcase
        end
      end
    end else if (addr_int == GlobalBase + PCU_OVF) begin
      rd_word = 32'(ovf_q);
    end else if (addr_int == GlobalBase + PCU_GCTRL) begin
      rd_word = {31'b0, freeze_q};
    end
  end

  // A fresh wrap outranks a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    rdata_d  = cr.read_en ? rd_word : rdata_q;
    freeze_d = wr_gctrl ? cr.write_data[0] : freeze_q;
    ovf_d    = (ovf_q & ~(wr_ovf ? cr.write_data[NumCounters-1:0] : '0)) | ovf_set;
    irq_d    = |(ovf_q & irq_en_vec);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_q    <= '0;
      freeze_q <= 1'b0;
      ovf_q    <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      evt_q    <= perf_event_i;
      freeze_q <= freeze_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cr.read_data   = rdata_q;
  assign overflow_irq_o = irq_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: register table plus multi-cycle corner sequences.
module tb_perf_counter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] perf_event;
  logic        irq;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd;

  localparam logic [34:0] Ev5 = 35'h20;

  always #5 clk = ~clk;

  perf_counter_unit_if #(.AddrWidth(8)) cr_if ();

  perf_counter_unit #(
    .NumEvents   (35),
    .NumCounters (4),
    .CounterWidth(48),
    .CrAddrWidth (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .perf_event_i  (perf_event),
    .cr            (cr_if.slave),
    .overflow_irq_o(irq)
  );

  typedef struct {
    logic        do_wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cr_if.write_en   = 1'b1;
    cr_if.address    = a;
    cr_if.write_data = d;
    cycle();
    cr_if.write_en = 1'b0;
  endtask

  task automatic rdreg(input logic [7:0] a, output logic [31:0] d);
    cr_if.read_en = 1'b1;
    cr_if.address = a;
    cycle();
    cr_if.read_en = 1'b0;
    d = cr_if.read_data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    cr_if.write_en   = 1'b0;
    cr_if.read_en    = 1'b0;
    cr_if.address    = '0;
    cr_if.write_data = '0;
    perf_event       = '0;
    do_reset();

    check("reset_rdata", cr_if.read_data, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 18; a++) begin
      rdreg(8'(a), rd);
      check($sformatf("reset_reg%0d", a), rd, 32'h0);
    end

    // Register write/readback table, including shadow and unmapped behaviour.
    vecs[0]  = '{1'b1, 8'd0,   32'hFFFF_FFFF, 32'h0000_003F};
    vecs[1]  = '{1'b1, 8'd5,   32'hFFFF_FFFF, 32'h0000_0003};
    vecs[2]  = '{1'b1, 8'd10,  32'h1234_5678, 32'h1234_5678};
    vecs[3]  = '{1'b1, 8'd15,  32'hFFFF_ABCD, 32'h0000_0000};
    vecs[4]  = '{1'b0, 8'd14,  32'h0,         32'h0000_0000};
    vecs[5]  = '{1'b0, 8'd15,  32'h0,         32'h0000_ABCD};
    vecs[6]  = '{1'b0, 8'd16,  32'h0,         32'h0000_0000};
    vecs[7]  = '{1'b1, 8'd17,  32'h0000_0003, 32'h0000_0001};
    vecs[8]  = '{1'b0, 8'd10,  32'h0,         32'h0000_0000};
    vecs[9]  = '{1'b0, 8'd14,  32'h0,         32'h0000_0000};
    vecs[10] = '{1'b0, 8'd15,  32'h0,         32'h0000_0000};
    vecs[11] = '{1'b1, 8'd17,  32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{1'b1, 8'd18,  32'h0000_FFFF, 32'h0000_0000};
    vecs[13] = '{1'b0, 8'd255, 32'h0,         32'h0000_0000};
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rdreg(vecs[i].addr, rd);
      check($sformatf("table%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
    end
    do_reset();

    // Basic count.
    wr(8'd0, 32'd5);
    wr(8'd1, 32'd1);
    perf_event = Ev5;
    repeat (10) cycle();
    perf_event = '0;
    repeat (2) cycle();
    rdreg(8'd2, rd); check("basic_lo", rd, 32'd10);
    rdreg(8'd3, rd); check("basic_hi", rd, 32'd0);

    // Wrap and irq timing.
    wr(8'd1, 32'd0);
    wr(8'd2, 32'hFFFF_FFFE);
    wr(8'd3, 32'h0000_FFFF);
    wr(8'd1, 32'd3);
    perf_event = Ev5;
    repeat (2) cycle();
    perf_event = '0;
    cycle();
    check("wrap_irq_not_yet", {31'b0, irq}, 32'h0);
    cycle();
    check("wrap_irq_set", {31'b0, irq}, 32'h1);
    rdreg(8'd16, rd); check("wrap_ovf", rd, 32'h1);
    rdreg(8'd2, rd);  check("wrap_lo", rd, 32'h0);
    rdreg(8'd3, rd);  check("wrap_hi", rd, 32'h0);
    wr(8'd16, 32'h1);
    check("w1c_irq_lag", {31'b0, irq}, 32'h1);
    cycle();
    check("w1c_irq_clear", {31'b0, irq}, 32'h0);

    // Atomic 64-bit read: HI returns the value latched at the LO read.
    wr(8'd1, 32'd1);
    wr(8'd2, 32'hFFFF_FFFF);
    wr(8'd3, 32'h1);
    rdreg(8'd2, rd); check("atomic_lo", rd, 32'hFFFF_FFFF);
    perf_event = Ev5;
    repeat (3) cycle();
    perf_event = '0;
    repeat (2) cycle();
    rdreg(8'd3, rd); check("atomic_hi_shadow", rd, 32'h1);
    rdreg(8'd2, rd); check("atomic_lo_after", rd, 32'h2);
    rdreg(8'd3, rd); check("atomic_hi_after", rd, 32'h2);

    // Write collides with increment: write wins.
    wr(8'd2, 32'd0);
    perf_event = Ev5;
    repeat (3) cycle();
    perf_event = '0;
    wr(8'd2, 32'd7);
    repeat (2) cycle();
    rdreg(8'd2, rd); check("coll_write_wins", rd, 32'd7);

    // clear_all with every counter counting.
    for (int c = 0; c < 4; c++) begin
      wr(8'(4 * c), 32'd5);
      wr(8'(4 * c + 1), 32'd1);
    end
    perf_event = Ev5;
    repeat (4) cycle();
    perf_event = '0;
    wr(8'd17, 32'h2);
    repeat (2) cycle();
    for (int c = 0; c < 4; c++) begin
      rdreg(8'(4 * c + 2), rd);
      check($sformatf("clear_all_c%0d", c), rd, 32'd0);
    end
    rdreg(8'd17, rd); check("gctrl_clear_reads0", rd, 32'd0);

    // W1C on the same edge as a new wrap: set wins.
    wr(8'd2, 32'hFFFF_FFFF);
    wr(8'd3, 32'h0000_FFFF);
    perf_event = Ev5;
    cycle();
    perf_event = '0;
    wr(8'd16, 32'h1);
    rdreg(8'd16, rd); check("w1c_vs_wrap", rd, 32'h1);
    wr(8'd16, 32'h1);
    rdreg(8'd16, rd); check("w1c_after", rd, 32'h0);

    // Freeze holds counts; counting resumes after unfreeze.
    wr(8'd2, 32'd0);
    wr(8'd17, 32'h1);
    perf_event = Ev5;
    repeat (5) cycle();
    perf_event = '0;
    repeat (2) cycle();
    rdreg(8'd2, rd); check("freeze_hold", rd, 32'd0);
    wr(8'd17, 32'h0);
    perf_event = Ev5;
    repeat (2) cycle();
    perf_event = '0;
    repeat (2) cycle();
    rdreg(8'd2, rd); check("unfreeze_count", rd, 32'd2);

    // Out-of-range event select never counts.
    wr(8'd0, 32'd40);
    wr(8'd2, 32'd0);
    perf_event = '1;
    repeat (5) cycle();
    perf_event = '0;
    repeat (2) cycle();
    rdreg(8'd0, rd); check("evsel40_readback", rd, 32'd40);
    rdreg(8'd2, rd); check("evsel40_no_count", rd, 32'd0);

    // Reset in the middle of counting with irq asserted.
    do_reset();
    wr(8'd0, 32'd5);
    wr(8'd2, 32'hFFFF_FFFF);
    wr(8'd3, 32'h0000_FFFF);
    wr(8'd1, 32'd3);
    perf_event = Ev5;
    repeat (5) cycle();
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    perf_event = '0;
    check("midreset_irq", {31'b0, irq}, 32'h0);
    check("midreset_rdata", cr_if.read_data, 32'h0);
    rdreg(8'd16, rd); check("midreset_ovf", rd, 32'h0);
    rdreg(8'd2, rd);  check("midreset_lo", rd, 32'h0);
    rdreg(8'd1, rd);  check("midreset_ctrl", rd, 32'h0);
    rdreg(8'd0, rd);  check("midreset_evsel", rd, 32'h0);
    wr(8'd0, 32'd5);
    wr(8'd1, 32'd1);
    perf_event = Ev5;
    cycle();
    perf_event = '0;
    repeat (2) cycle();
    rdreg(8'd2, rd); check("post_reset_first", rd, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
